// File: rtl/forth_pkg.sv
// Shared constants and loader state encoding for the Forth core.
package forth_pkg;

  localparam logic [7:0]  LOADER_MAGIC = 8'hA5;
  localparam logic [15:0] OP_NOP       = 16'he040;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } loader_state_e;

  // States in which a frame is being received.
  function automatic logic is_loading(loader_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/forth_boot_loader.sv
// Boot/reload sequencer: receives a framed image byte stream, writes it into
// instruction RAM and holds the core in reset until the checksum matches.
module forth_boot_loader
  import forth_pkg::*;
#(
  parameter int unsigned iaddr_width = 10,
  parameter int unsigned instr_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic [iaddr_width-1:0] cpu_iaddr,
  output logic                   cpu_reset,
  output logic [iaddr_width-1:0] imem_addr,
  output logic [instr_width-1:0] imem_wdata,
  output logic                   imem_we,
  output logic                   loading,
  output logic                   error
);

  localparam int unsigned CNT_W = iaddr_width + 1;
  localparam int unsigned DEPTH = 32'd1 << iaddr_width;

  loader_state_e          state_q, state_d;
  logic [7:0]             len_hi_q, len_hi_d;
  logic [7:0]             hi_q, hi_d;
  logic [7:0]             csum_q, csum_d;
  logic [iaddr_width-1:0] waddr_q, waddr_d;
  logic [CNT_W-1:0]       remain_q, remain_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic                   we_q, we_d;
  logic [instr_width-1:0] wdata_q, wdata_d;
  logic                   error_q, error_d;
  logic                   loading_q, loading_d;
  logic [15:0]            len_w;

  assign len_w = {len_hi_q, rx_data};

  // Next-state, counters and registered output values.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    hi_d        = hi_q;
    csum_d      = csum_q;
    waddr_d     = we_q ? waddr_q + iaddr_width'(1) : waddr_q;
    remain_d    = remain_q;
    cpu_reset_d = cpu_reset_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    error_d     = error_q;
    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (rx_data == LOADER_MAGIC) begin
            state_d     = ST_LEN_HI;
            waddr_d     = '0;
            remain_d    = '0;
            csum_d      = '0;
            cpu_reset_d = 1'b1;
            error_d     = 1'b0;
          end
        end
        ST_LEN_HI: begin
          len_hi_d = rx_data;
          csum_d   = csum_q ^ rx_data;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          csum_d = csum_q ^ rx_data;
          if (len_w == 16'd0) begin
            state_d = ST_CSUM;
          end else if (32'(len_w) > DEPTH) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            remain_d = CNT_W'(len_w);
            state_d  = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          csum_d   = csum_q ^ rx_data;
          we_d     = 1'b1;
          wdata_d  = instr_width'({hi_q, rx_data});
          remain_d = remain_q - CNT_W'(1);
          state_d  = (remain_q == CNT_W'(1)) ? ST_CSUM : ST_DATA_HI;
        end
        ST_CSUM: begin
          if (rx_data == csum_q) begin
            state_d     = ST_RUN;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    loading_d = is_loading(state_d);
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_hi_q    <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      waddr_q     <= '0;
      remain_q    <= '0;
      cpu_reset_q <= 1'b1;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      error_q     <= 1'b0;
      loading_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      waddr_q     <= waddr_d;
      remain_q    <= remain_d;
      cpu_reset_q <= cpu_reset_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      error_q     <= error_d;
      loading_q   <= loading_d;
    end
  end

  // RAM port belongs to the loader while the core is held in reset.
  assign imem_addr  = cpu_reset_q ? waddr_q : cpu_iaddr;
  assign imem_we    = we_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign error      = error_q;
  assign loading    = loading_q;
  assign rx_ready   = 1'b1;

endmodule

// File: tb/tb_forth_boot_loader.sv
// Scoreboard bench for forth_boot_loader: expected RAM writes are queued by
// the stimulus and consumed by a monitor watching imem_we.
module tb_forth_boot_loader;
  import forth_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  cpu_iaddr;
  logic        cpu_reset;
  logic [9:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        imem_we;
  logic        loading;
  logic        error;

  forth_boot_loader #(.iaddr_width(10), .instr_width(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .cpu_iaddr(cpu_iaddr), .cpu_reset(cpu_reset),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
    .loading(loading), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frm[$];
  int         total = 0;
  int         bad   = 0;
  int         we_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && imem_we === 1'b1) begin
      wr_t e;
      we_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(e.a));
        chk("write_data", 32'(imem_wdata), 32'(e.d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Sends frm back-to-back, one byte per cycle.
  task automatic send_frm();
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
    frm.delete();
  endtask

  task automatic expect_wr(input logic [9:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int         we0;
  logic [7:0] cs;
  logic [15:0] w;

  initial begin
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cpu_iaddr = 10'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    reset = 1'b0;
    idle(2);

    // Good two-word frame.
    we0 = we_cnt;
    expect_wr(10'd0, 16'h1234);
    expect_wr(10'd1, OP_NOP);
    send_byte(8'hA5);
    chk("a_loading", 32'(loading), 32'd1);
    chk("a_cpu_reset_load", 32'(cpu_reset), 32'd1);
    frm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hE0, 8'h40};
    send_frm();
    chk("a_cpu_reset_before_csum", 32'(cpu_reset), 32'd1);
    send_byte(8'h84);
    chk("a_cpu_reset_released", 32'(cpu_reset), 32'd0);
    chk("a_loading_done", 32'(loading), 32'd0);
    chk("a_error", 32'(error), 32'd0);
    chk("a_we_count", 32'(we_cnt - we0), 32'd2);
    cpu_iaddr = 10'h155;
    #1;
    chk("a_addr_mux_cpu", 32'(imem_addr), 32'h155);

    // Same frame, wrong checksum.
    we0 = we_cnt;
    expect_wr(10'd0, 16'h1234);
    expect_wr(10'd1, 16'hE040);
    frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hE0, 8'h40, 8'h85};
    send_frm();
    chk("b_error", 32'(error), 32'd1);
    chk("b_cpu_reset", 32'(cpu_reset), 32'd1);
    idle(3);
    chk("b_error_sticky", 32'(error), 32'd1);
    chk("b_cpu_reset_held", 32'(cpu_reset), 32'd1);
    chk("b_we_count", 32'(we_cnt - we0), 32'd2);
    expect_wr(10'd0, 16'h1234);
    expect_wr(10'd1, 16'hE040);
    send_byte(8'hA5);
    chk("b_error_cleared", 32'(error), 32'd0);
    frm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hE0, 8'h40, 8'h84};
    send_frm();
    chk("b_recover_release", 32'(cpu_reset), 32'd0);
    chk("b_recover_error", 32'(error), 32'd0);

    // Empty frame.
    we0 = we_cnt;
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frm();
    chk("c_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("c_we_count", 32'(we_cnt - we0), 32'd0);
    cpu_iaddr = 10'h2AA;
    #1;
    chk("c_addr_mux", 32'(imem_addr), 32'h2AA);

    // Oversize length: 0x0401 words.
    we0 = we_cnt;
    frm = '{8'hA5, 8'h04, 8'h01};
    send_frm();
    chk("d_error", 32'(error), 32'd1);
    chk("d_loading", 32'(loading), 32'd0);
    chk("d_cpu_reset", 32'(cpu_reset), 32'd1);
    frm = '{8'h12, 8'h34, 8'h56};
    send_frm();
    chk("d_we_count", 32'(we_cnt - we0), 32'd0);
    chk("d_error_held", 32'(error), 32'd1);

    // Maximum length 0x0400 fills the whole RAM; data includes 0xA5 bytes.
    we0 = we_cnt;
    cs = 8'h04 ^ 8'h00;
    frm = '{8'hA5, 8'h04, 8'h00};
    for (int i = 0; i < 1024; i++) begin
      w = 16'(i) ^ 16'hC3A5;
      frm.push_back(w[15:8]);
      frm.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
      expect_wr(10'(i), w);
    end
    frm.push_back(cs);
    send_frm();
    chk("e_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("e_error", 32'(error), 32'd0);
    chk("e_we_count", 32'(we_cnt - we0), 32'd1024);

    // In RUN: stray byte ignored, magic starts a reload at address 0.
    send_byte(8'h11);
    chk("f_stray_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("f_stray_loading", 32'(loading), 32'd0);
    expect_wr(10'd0, 16'hABCD);
    send_byte(8'hA5);
    chk("f_reload_cpu_reset", 32'(cpu_reset), 32'd1);
    frm = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h67};
    send_frm();
    chk("f_reload_release", 32'(cpu_reset), 32'd0);

    // Reset between DATA_HI and DATA_LO.
    we0 = we_cnt;
    frm = '{8'hA5, 8'h00, 8'h02, 8'h12};
    send_frm();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("g_rst_loading", 32'(loading), 32'd0);
    chk("g_rst_we", 32'(imem_we), 32'd0);
    chk("g_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    reset = 1'b0;
    idle(2);
    chk("g_we_none", 32'(we_cnt - we0), 32'd0);
    expect_wr(10'd0, 16'h1234);
    expect_wr(10'd1, 16'hE040);
    frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hE0, 8'h40, 8'h84};
    send_frm();
    chk("g_release", 32'(cpu_reset), 32'd0);
    chk("g_we_count", 32'(we_cnt - we0), 32'd2);

    idle(4);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
